// File: rtl/ysyx_24080006_counter_csr_if.sv
// CSR request/response channel between the CSR decode unit (master) and the
// performance-counter CSR stage (slave).
//   req_*  : valid/ready request carrying op, address, write data and nowr flag
//   resp_* : valid/ready response carrying old CSR value and error flag
interface ysyx_24080006_counter_csr_if;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned AWIDTH = 12;
    localparam int unsigned OWIDTH = 2;

    logic              req_valid;
    logic              req_ready;
    logic [OWIDTH-1:0] req_op;
    logic [AWIDTH-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              req_nowr;
    logic              resp_valid;
    logic              resp_ready;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_nowr, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_nowr, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/ysyx_24080006_counter_csr.sv
// CSR access stage for the mcycle/minstret performance counters.
// Executes CSRRW/CSRRS/CSRRC on counter halves (and their read-only user
// shadows) and on mcountinhibit, and drives the counters' incr/write controls.
// Ports:
//   i_clock, i_reset          : clock, synchronous active-low reset
//   csr_bus                   : request/response handshake (slave side)
//   i_instret_pulse           : one instruction retired this cycle
//   o_ctr_wdata               : write data shared by both counters
//   o_cycle_*/o_instret_*     : incr enable and half write enables per counter
//   i_cycle_*/i_instret_*     : current counter halves
module ysyx_24080006_counter_csr (
    input  logic                           i_clock,
    input  logic                           i_reset,
    ysyx_24080006_counter_csr_if.slave     csr_bus,
    input  logic                           i_instret_pulse,
    output logic [31:0]                    o_ctr_wdata,
    output logic                           o_cycle_incr_en,
    output logic                           o_cycle_high_we,
    output logic                           o_cycle_low_we,
    input  logic [31:0]                    i_cycle_high_rdata,
    input  logic [31:0]                    i_cycle_low_rdata,
    output logic                           o_instret_incr_en,
    output logic                           o_instret_high_we,
    output logic                           o_instret_low_we,
    input  logic [31:0]                    i_instret_high_rdata,
    input  logic [31:0]                    i_instret_low_rdata
);
    localparam int unsigned XLEN   = 32;
    localparam int unsigned AWIDTH = 12;
    localparam int unsigned WEW    = 4;

    localparam logic [AWIDTH-1:0] A_MCOUNTINHIBIT = 12'h320;
    localparam logic [AWIDTH-1:0] A_MCYCLE        = 12'hB00;
    localparam logic [AWIDTH-1:0] A_MINSTRET      = 12'hB02;
    localparam logic [AWIDTH-1:0] A_MCYCLEH       = 12'hB80;
    localparam logic [AWIDTH-1:0] A_MINSTRETH     = 12'hB82;
    localparam logic [AWIDTH-1:0] A_CYCLE         = 12'hC00;
    localparam logic [AWIDTH-1:0] A_INSTRET       = 12'hC02;
    localparam logic [AWIDTH-1:0] A_CYCLEH        = 12'hC80;
    localparam logic [AWIDTH-1:0] A_INSTRETH      = 12'hC82;

    // write-enable vector layout: {cycle_high, cycle_low, instret_high, instret_low}
    localparam logic [WEW-1:0] WE_CYC_HI = 4'b1000;
    localparam logic [WEW-1:0] WE_CYC_LO = 4'b0100;
    localparam logic [WEW-1:0] WE_INS_HI = 4'b0010;
    localparam logic [WEW-1:0] WE_INS_LO = 4'b0001;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WRITE, S_RESP} state_e;

    state_e            r_state, w_state_nxt;
    logic [1:0]        r_op;
    logic [AWIDTH-1:0] r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic              r_nowr;
    logic [1:0]        r_inhibit;      // {IR, CY}
    logic [1:0]        r_inh_wdata;    // pending {IR, CY} for the WRITE cycle
    logic              r_inh_sel;
    logic              r_resp_valid;
    logic [XLEN-1:0]   r_resp_rdata;
    logic              r_resp_err;
    logic [WEW-1:0]    r_we;
    logic [XLEN-1:0]   r_ctr_wdata;

    logic              w_latch;
    logic              w_known, w_shadow, w_sel_inh, w_err;
    logic [WEW-1:0]    w_sel_we;
    logic [XLEN-1:0]   w_old, w_new, w_inhibit_val;
    logic [1:0]        w_inhibit_nxt, w_inh_wdata_nxt;
    logic              w_inh_sel_nxt;
    logic              w_resp_valid_nxt, w_resp_err_nxt;
    logic [XLEN-1:0]   w_resp_rdata_nxt, w_ctr_wdata_nxt;
    logic [WEW-1:0]    w_we_nxt;

    // mcountinhibit is WARL: only CY (bit 0) and IR (bit 2) exist
    assign w_inhibit_val = {29'b0, r_inhibit[1], 1'b0, r_inhibit[0]};

    // address decode and old-value select
    always_comb begin
        w_known   = 1'b1;
        w_shadow  = 1'b0;
        w_sel_inh = 1'b0;
        w_sel_we  = '0;
        w_old     = '0;
        case (r_addr)
            A_MCOUNTINHIBIT: begin w_sel_inh = 1'b1;   w_old = w_inhibit_val;        end
            A_MCYCLE:        begin w_sel_we = WE_CYC_LO; w_old = i_cycle_low_rdata;    end
            A_MCYCLEH:       begin w_sel_we = WE_CYC_HI; w_old = i_cycle_high_rdata;   end
            A_MINSTRET:      begin w_sel_we = WE_INS_LO; w_old = i_instret_low_rdata;  end
            A_MINSTRETH:     begin w_sel_we = WE_INS_HI; w_old = i_instret_high_rdata; end
            A_CYCLE:         begin w_shadow = 1'b1;    w_old = i_cycle_low_rdata;    end
            A_CYCLEH:        begin w_shadow = 1'b1;    w_old = i_cycle_high_rdata;   end
            A_INSTRET:       begin w_shadow = 1'b1;    w_old = i_instret_low_rdata;  end
            A_INSTRETH:      begin w_shadow = 1'b1;    w_old = i_instret_high_rdata; end
            default:         w_known = 1'b0;
        endcase
    end

    // read-modify-write result and error classification
    always_comb begin
        w_new = w_old;
        case (r_op)
            2'b01:   w_new = r_wdata;
            2'b10:   w_new = w_old | r_wdata;
            2'b11:   w_new = w_old & ~r_wdata;
            default: w_new = w_old;
        endcase
        w_err = !w_known || (r_op == 2'b00) || (w_shadow && !r_nowr);
    end

    // next-state and registered-output logic
    always_comb begin
        w_state_nxt      = r_state;
        w_latch          = 1'b0;
        w_inhibit_nxt    = r_inhibit;
        w_inh_wdata_nxt  = r_inh_wdata;
        w_inh_sel_nxt    = r_inh_sel;
        w_resp_valid_nxt = r_resp_valid;
        w_resp_rdata_nxt = r_resp_rdata;
        w_resp_err_nxt   = r_resp_err;
        w_we_nxt         = '0;
        w_ctr_wdata_nxt  = r_ctr_wdata;
        case (r_state)
            S_IDLE: begin
                if (csr_bus.req_valid) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_resp_err_nxt   = w_err;
                w_resp_rdata_nxt = w_err ? '0 : w_old;
                w_inh_sel_nxt    = w_sel_inh;
                w_inh_wdata_nxt  = {w_new[2], w_new[0]};
                if (!w_err && !r_nowr) begin
                    w_state_nxt = S_WRITE;
                    w_we_nxt    = w_sel_we;
                    if (!w_sel_inh) w_ctr_wdata_nxt = w_new;
                end else begin
                    w_state_nxt      = S_RESP;
                    w_resp_valid_nxt = 1'b1;
                end
            end
            S_WRITE: begin
                if (r_inh_sel) w_inhibit_nxt = r_inh_wdata;
                w_state_nxt      = S_RESP;
                w_resp_valid_nxt = 1'b1;
            end
            S_RESP: begin
                if (csr_bus.resp_ready) begin
                    w_resp_valid_nxt = 1'b0;
                    w_state_nxt      = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // state and output registers
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state      <= S_IDLE;
            r_op         <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_nowr       <= 1'b0;
            r_inhibit    <= '0;
            r_inh_wdata  <= '0;
            r_inh_sel    <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_we         <= '0;
            r_ctr_wdata  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_inhibit    <= w_inhibit_nxt;
            r_inh_wdata  <= w_inh_wdata_nxt;
            r_inh_sel    <= w_inh_sel_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
            r_resp_err   <= w_resp_err_nxt;
            r_we         <= w_we_nxt;
            r_ctr_wdata  <= w_ctr_wdata_nxt;
            if (w_latch) begin
                r_op    <= csr_bus.req_op;
                r_addr  <= csr_bus.req_addr;
                r_wdata <= csr_bus.req_wdata;
                r_nowr  <= csr_bus.req_nowr;
            end
        end
    end

    assign csr_bus.req_ready  = (r_state == S_IDLE);
    assign csr_bus.resp_valid = r_resp_valid;
    assign csr_bus.resp_rdata = r_resp_rdata;
    assign csr_bus.resp_err   = r_resp_err;

    assign o_ctr_wdata       = r_ctr_wdata;
    assign o_cycle_high_we   = r_we[3];
    assign o_cycle_low_we    = r_we[2];
    assign o_instret_high_we = r_we[1];
    assign o_instret_low_we  = r_we[0];

    // counters run whenever not inhibited; instret also needs a retire pulse
    assign o_cycle_incr_en   = ~r_inhibit[0];
    assign o_instret_incr_en = i_instret_pulse & ~r_inhibit[1];
endmodule
